// File: rtl/fp_divide_seq.sv
// fp_divide_seq: sequential IEEE-style floating-point divider.
// One quotient bit per clock (restoring division), followed by a single
// normalise/round cycle. Round-to-nearest-even. Subnormal inputs are
// flushed to zero. Special operands bypass the datapath.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid / in_ready   operand handshake (in_ready only while idle)
//   inputA, inputB        dividend, divisor {sign, exponent, fraction}
//   out_valid / out_ready result handshake
//   out, flags            quotient, {invalid, div_by_zero, overflow, underflow}
module fp_divide_seq #(
  parameter int EXP_W = 8,
  parameter int MAN_W = 23
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [EXP_W+MAN_W:0]   inputA,
  input  logic [EXP_W+MAN_W:0]   inputB,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [EXP_W+MAN_W:0]   out,
  output logic [3:0]             flags
);
  localparam int W  = 1 + EXP_W + MAN_W;
  localparam int QW = MAN_W + 3;          // integer + fraction + guard + round
  localparam int CW = $clog2(QW + 1);
  localparam int EW = EXP_W + 2;          // signed exponent with headroom
  localparam logic signed [EW-1:0] BIAS = EW'((1 << (EXP_W - 1)) - 1);
  localparam logic signed [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, NORM, DONE} state_t;
  state_t state, state_nxt;

  logic                 sign_r;
  logic signed [EW-1:0] exp_r;
  logic [MAN_W+1:0]     rem_r;
  logic [MAN_W:0]       div_r;
  logic [QW-1:0]        quo_r;
  logic [CW-1:0]        cnt_r;

  // operand decode
  logic [EXP_W-1:0] exp_a, exp_b;
  logic [MAN_W-1:0] frac_a, frac_b;
  logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b, sign_q, accept;
  assign exp_a  = inputA[W-2:MAN_W];
  assign exp_b  = inputB[W-2:MAN_W];
  assign frac_a = inputA[MAN_W-1:0];
  assign frac_b = inputB[MAN_W-1:0];
  assign nan_a  = (&exp_a) && (|frac_a);
  assign nan_b  = (&exp_b) && (|frac_b);
  assign inf_a  = (&exp_a) && !(|frac_a);
  assign inf_b  = (&exp_b) && !(|frac_b);
  assign zero_a = !(|exp_a);
  assign zero_b = !(|exp_b);
  assign sign_q = inputA[W-1] ^ inputB[W-1];
  assign accept = in_valid && in_ready;

  // special-case resolution straight from the operand inputs
  logic         special;
  logic [W-1:0] sp_out;
  logic [3:0]   sp_flags;
  always_comb begin
    special  = 1'b1;
    sp_out   = '0;
    sp_flags = '0;
    if (nan_a || nan_b || (zero_a && zero_b) || (inf_a && inf_b)) begin
      sp_out   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
      sp_flags = 4'b1000;
    end else if (inf_a) begin
      sp_out = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (zero_b) begin
      sp_out   = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      sp_flags = 4'b0100;
    end else if (zero_a || inf_b) begin
      sp_out = {sign_q, {(W-1){1'b0}}};
    end else begin
      special = 1'b0;
    end
  end

  // one restoring-division step
  logic [MAN_W+1:0] div_ext, rem_sub;
  logic             q_bit;
  assign div_ext = {1'b0, div_r};
  assign q_bit   = rem_r >= div_ext;
  assign rem_sub = q_bit ? rem_r - div_ext : rem_r;

  // normalise and round
  logic                 q_int, rnd, stk, inc, cy;
  logic [MAN_W-1:0]     frac_n, frac_rnd;
  logic signed [EW-1:0] e_n, e_rnd;
  logic [W-1:0]         norm_out;
  logic [3:0]           norm_flags;
  always_comb begin
    q_int  = quo_r[QW-1];
    // integer bit clear means quotient in [0.5,1): use one bit lower
    frac_n = q_int ? quo_r[MAN_W+1:2] : quo_r[MAN_W:1];
    rnd    = q_int ? quo_r[1] : quo_r[0];
    stk    = (q_int && quo_r[0]) || (|rem_r);
    e_n    = q_int ? exp_r : exp_r - EW'(1);
    inc    = rnd && (stk || frac_n[0]);
    {cy, frac_rnd} = {1'b0, frac_n} + {{MAN_W{1'b0}}, inc};
    e_rnd  = e_n + EW'(cy);
    norm_flags = '0;
    if (!e_rnd[EW-1] && e_rnd >= EMAX) begin
      norm_out   = {sign_r, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      norm_flags = 4'b0010;
    end else if (e_rnd[EW-1] || e_rnd == '0) begin
      norm_out   = {sign_r, {(W-1){1'b0}}};
      norm_flags = 4'b0001;
    end else begin
      norm_out = {sign_r, e_rnd[EXP_W-1:0], frac_rnd};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (accept) state_nxt = special ? DONE : DIVIDE;
      end
      DIVIDE: if (cnt_r == CW'(QW - 1)) state_nxt = NORM;
      NORM:   state_nxt = DONE;
      DONE:   if (out_valid && out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sign_r    <= 1'b0;
      exp_r     <= '0;
      rem_r     <= '0;
      div_r     <= '0;
      quo_r     <= '0;
      cnt_r     <= '0;
      out       <= '0;
      flags     <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          sign_r <= sign_q;
          cnt_r  <= '0;
          quo_r  <= '0;
          if (special) begin
            out   <= sp_out;
            flags <= sp_flags;
          end else begin
            exp_r <= $signed({2'b00, exp_a}) - $signed({2'b00, exp_b}) + BIAS;
            rem_r <= {1'b0, 1'b1, frac_a};
            div_r <= {1'b1, frac_b};
          end
        end
        DIVIDE: begin
          quo_r <= {quo_r[QW-2:0], q_bit};
          // partial remainder is below the divisor, so the shift cannot overflow
          rem_r <= {rem_sub[MAN_W:0], 1'b0};
          cnt_r <= cnt_r + CW'(1);
        end
        NORM: begin
          out       <= norm_out;
          flags     <= norm_flags;
          out_valid <= 1'b1;
        end
        // special results enter DONE with out_valid low and raise it here,
        // one cycle after the accept edge
        DONE: out_valid <= !(out_valid && out_ready);
        default: out_valid <= 1'b0;
      endcase
    end
  end
endmodule
